spi_wr_arbiter: RTL and testbench
=================================

# spi_wr_arbiter

Two-requester write arbiter and sequencer in front of the `spi_block` transmit-side write port (`wr` / `data_in`). It accepts 32-bit words from two independent producers over valid/ready handshakes and grants them round-robin. It turns each accepted word into a single-cycle `wr` pulse followed by an enforced idle gap. It stalls while the `spi_block` FIFO reports full, and drops a stalled word after a timeout so a wedged FIFO cannot hang either producer.

## Interface
Parameters:
- `DATA_W`, 32, word width; must match the `spi_block` `data_in` width.
- `GAP_CYCLES`, 2, minimum idle cycles after each `wr` pulse (0 allowed).
- `TIMEOUT`, 64, cycles of continuous full-stall before a word is dropped (≥1).
- `CNT_W`, 8, width of the drop counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_data`  in  DATA_W  requester 0 word.
- `req0_ready`  out  1  requester 0 word accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `full_alarm`  in  1  `spi_block` FIFO full.
- `empty_alarm`  in  1  `spi_block` FIFO empty.
- `wr`  out  1  write strobe to `spi_block`.
- `spi_data`  out  DATA_W  word to `spi_block` `data_in`.
- `grant`  out  2  one-hot, last accepted requester.
- `drop`  out  1  one-cycle pulse when a word is discarded.
- `drop_count`  out  CNT_W  number of dropped words; saturating.
- `drained`  out  1  high when the arbiter is IDLE, neither requester is valid, and `empty_alarm` is high.

## Operation
- State machine states: IDLE, WRITE, GAP.
- **Winner selection:**
  - Only one requester valid: that requester wins.
  - Both valid: the requester pointed to by the round-robin pointer wins.
  - Pointer after reset: requester 0.
- **IDLE, FIFO not full:**
  - `reqN_ready` = IDLE && winner==N && !`full_alarm` (combinational).
  - On accept (valid && ready): latch the data into `spi_data`, set `grant`, point the round-robin pointer at the other requester, go to WRITE.
- **IDLE, FIFO full:**
  - While the FIFO is full and any requester is valid, a stall counter increments; otherwise it clears.
  - At the cycle the counter reaches TIMEOUT−1, the winner's `ready` is forced high and the word is accepted.
  - The dropped word produces no `wr`. `drop` pulses on the next cycle and `drop_count` increments, saturating at 2^CNT_W−1.
  - The round-robin pointer updates as for a normal accept. The state stays IDLE and the stall counter clears.
- **WRITE:** `wr`=1 for exactly one cycle. Next state is GAP, or IDLE if GAP_CYCLES==0.
- **GAP:** `wr`=0 for GAP_CYCLES cycles, then IDLE.
- `spi_data` holds its value until the next normal accept; drops do not update it.
- `full_alarm` is sampled only in IDLE. A full condition that rises during WRITE or GAP does not abort the pending `wr`.
- **Reset, including mid-WRITE or mid-GAP:**
  - State goes to IDLE.
  - `wr`, `drop`, both `ready` signals, `spi_data`, `grant`, `drop_count` and the stall counter go to 0.
  - The round-robin pointer returns to requester 0.
  - A latched but unwritten word is lost.

## Timing
- Accept in cycle N → `wr` high in cycle N+1, with `spi_data` valid in N+1.
- Earliest next accept: cycle N+2+GAP_CYCLES. With GAP_CYCLES=0, throughput is one word every 2 cycles.
- Drop: the stall starts in cycle S → forced accept in cycle S+TIMEOUT−1 → `drop` pulse in cycle S+TIMEOUT.
- If `full_alarm` falls before the timeout, a normal accept occurs in the same cycle it falls.
- `ready` depends combinationally on `valid`, so requesters must not make `valid` depend on `ready`.

## Configuration
- `SPI_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins when both are valid, and the round-robin pointer logic is removed. `grant` still reports the accepted requester.
  - Undefined (default): round-robin selection as above.

## Structure
- The shared package `spi_pkg` holds:
  - the state enum type `arb_state_t` (IDLE/WRITE/GAP);
  - the default constants `SPI_DATA_W`=32 and `SPI_ARB_GAP`=2.
- Sub-module `rr_arb2`: a combinational 2-way winner picker with a registered pointer-update input. It is also reused by the macro variant, with the pointer tied to 0.

## Test plan
- **Single write.** `req0_valid`=1 with `req0_data`=32'h0 while not full → `req0_ready` for 1 cycle, `wr` in the next cycle with `spi_data`=32'h0, `grant`=2'b01.
- **Round-robin.** Both requesters valid continuously, req0=32'h80000000 and req1=32'h00000001, GAP_CYCLES=2 → grants alternate 01, 10, 01, 10; `wr` pulses are exactly 4 cycles apart.
- **Full stall.** `full_alarm`=1 for 10 cycles with req1 valid → no `ready` and no `wr`. After `full_alarm` falls → accept in that cycle and `wr` one cycle later.
- **Timeout drop.** `full_alarm` held at 1 with TIMEOUT=64 and req0 valid → `req0_ready` in stall cycle 63, `drop` pulse in cycle 64, `drop_count`=1, no `wr`, `spi_data` unchanged.
- **Reset during WRITE.** Assert `rst` in the WRITE cycle → `wr`=0 from the next cycle; all outputs read 0 after reset; the next accept grants req0 when both requesters are valid.
- **Drained and saturation.** Idle with no valid and `empty_alarm`=1 → `drained`=1. Force 300 drops with CNT_W=8 → `drop_count` holds 255.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default constants for the spi_block write-side arbiter.
package spi_pkg;

  localparam int SPI_DATA_W  = 32;
  localparam int SPI_ARB_GAP = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner picker: combinational selection, registered round-robin pointer.
// With FIXED set the pointer is a constant 0, giving requester 0 priority.
module rr_arb2 #(
  parameter bit FIXED = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       update,
  output logic       winner
);

  logic ptr;

  generate
    if (FIXED) begin : g_fixed
      assign ptr = 1'b0;
    end else begin : g_rr
      // After an accept the pointer favours the requester that just lost.
      always_ff @(posedge clk) begin
        if (rst) begin
          ptr <= 1'b0;
        end else if (update) begin
          ptr <= ~winner;
        end
      end
    end
  endgenerate

  always_comb begin
    winner = 1'b0;
    if (valid == 2'b11) begin
      winner = ptr;
    end else if (valid[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/spi_wr_arbiter.sv
// Two-requester round-robin write arbiter/sequencer in front of spi_block wr/data_in.
// Define SPI_ARB_FIXED_PRIO_EN to make requester 0 always win when both are valid.
module spi_wr_arbiter
  import spi_pkg::*;
#(
  parameter int DATA_W     = SPI_DATA_W,
  parameter int GAP_CYCLES = SPI_ARB_GAP,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              full_alarm,
  input  logic              empty_alarm,
  output logic              wr,
  output logic [DATA_W-1:0] spi_data,
  output logic [1:0]        grant,
  output logic              drop,
  output logic [CNT_W-1:0]  drop_count,
  output logic              drained
);

  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_t          state;
  logic [STALL_W-1:0]  stall_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic                winner;
  logic                any_valid;
  logic                idle;
  logic                timeout_hit;
  logic                accept;
  logic [DATA_W-1:0]   win_data;

`ifdef SPI_ARB_FIXED_PRIO_EN
  rr_arb2 #(.FIXED(1'b1)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .update (accept),
    .winner (winner)
  );
`else
  rr_arb2 #(.FIXED(1'b0)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .update (accept),
    .winner (winner)
  );
`endif

  // A timed-out stall forces an accept even though the FIFO is still full.
  always_comb begin
    any_valid   = req0_valid | req1_valid;
    idle        = (state == IDLE);
    timeout_hit = full_alarm && (stall_cnt == STALL_LAST);
    accept      = !rst && idle && any_valid && (!full_alarm || timeout_hit);
    win_data    = winner ? req1_data : req0_data;
    req0_ready  = accept && !winner;
    req1_ready  = accept && winner;
    drained     = idle && !any_valid && empty_alarm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr         <= 1'b0;
      drop       <= 1'b0;
      spi_data   <= '0;
      grant      <= '0;
      drop_count <= '0;
      stall_cnt  <= '0;
      gap_cnt    <= '0;
    end else begin
      wr   <= 1'b0;
      drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            grant     <= winner ? 2'b10 : 2'b01;
            stall_cnt <= '0;
            if (full_alarm) begin
              drop <= 1'b1;
              if (drop_count != CNT_MAX) begin
                drop_count <= drop_count + 1'b1;
              end
            end else begin
              spi_data <= win_data;
              wr       <= 1'b1;
              state    <= WRITE;
            end
          end else if (full_alarm && any_valid) begin
            stall_cnt <= stall_cnt + 1'b1;
          end else begin
            stall_cnt <= '0;
          end
        end
        WRITE: begin
          stall_cnt <= '0;
          gap_cnt   <= '0;
          state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_wr_arbiter.sv
// Randomized scoreboard bench for spi_wr_arbiter against a cycle-arithmetic reference model.
module tb_spi_wr_arbiter;

  localparam int DW  = 32;
  localparam int GAP = 2;
  localparam int TO  = 64;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic          full_alarm = 1'b0;
  logic          empty_alarm = 1'b0;
  logic          wr;
  logic [DW-1:0] spi_data;
  logic [1:0]    grant;
  logic          drop;
  logic [CW-1:0] drop_count;
  logic          drained;

  spi_wr_arbiter #(
    .DATA_W     (DW),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TO),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .full_alarm  (full_alarm),
    .empty_alarm (empty_alarm),
    .wr          (wr),
    .spi_data    (spi_data),
    .grant       (grant),
    .drop        (drop),
    .drop_count  (drop_count),
    .drained     (drained)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  grant;
  } wr_ev_t;

  typedef struct {
    int          due;
    int          cnt;
    logic [31:0] data;
  } drop_ev_t;

  wr_ev_t   wrq[$];
  drop_ev_t dropq[$];

  // Reference model state: arbiter is busy until cycle busy_until.
  int          busy_until = 0;
  bit          ptr = 1'b0;
  int          stall = 0;
  int          dcnt = 0;
  logic [31:0] last_data = '0;
  bit          prev_rst = 1'b0;
  bit          last_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit v0, input bit v1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input bit f, input bit e);
    bit idle;
    bit w;
    bit er0;
    bit er1;
    bit sel;
    @(posedge clk);
    #1;
    rst         = r;
    req0_valid  = v0;
    req1_valid  = v1;
    req0_data   = d0;
    req1_data   = d1;
    full_alarm  = f;
    empty_alarm = e;
    #1;
    if (prev_rst) begin
      chk("rst_wr", wr, 0);
      chk("rst_drop", drop, 0);
      chk("rst_spi_data", spi_data, 0);
      chk("rst_grant", grant, 0);
      chk("rst_drop_count", drop_count, 0);
    end
    idle = (cyc >= busy_until);
    er0 = 1'b0;
    er1 = 1'b0;
    last_acc = 1'b0;
`ifdef SPI_ARB_FIXED_PRIO_EN
    sel = 1'b0;
`else
    sel = ptr;
`endif
    if (!r && idle && (v0 || v1)) begin
      w = (v0 && v1) ? sel : v1;
      if (!f) begin
        wrq.push_back('{due: cyc + 1, data: (w ? d1 : d0), grant: (w ? 2'b10 : 2'b01)});
        last_data  = w ? d1 : d0;
        busy_until = cyc + 2 + GAP;
        ptr        = !w;
        stall      = 0;
        last_acc   = 1'b1;
      end else if (stall == TO - 1) begin
        dcnt = (dcnt < (1 << CW) - 1) ? dcnt + 1 : dcnt;
        dropq.push_back('{due: cyc + 1, cnt: dcnt, data: last_data});
        ptr      = !w;
        stall    = 0;
        last_acc = 1'b1;
      end else begin
        stall++;
      end
      if (last_acc) begin
        if (w) er1 = 1'b1;
        else   er0 = 1'b1;
      end
    end else begin
      stall = 0;
    end
    chk("req0_ready", req0_ready, er0);
    chk("req1_ready", req1_ready, er1);
    chk("drained", drained, idle && !v0 && !v1 && e);
    if (r) begin
      busy_until = cyc + 1;
      ptr        = 1'b0;
      stall      = 0;
      dcnt       = 0;
      last_data  = '0;
    end
    prev_rst = r;
  endtask

  // Monitor: consumes expected events whenever the DUT presents wr or drop.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (wr === 1'b1) begin
        if (wrq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wr_unexpected at cycle %0d: got wr=1 required wr=0", cyc);
        end else begin
          wr_ev_t ev;
          ev = wrq.pop_front();
          chk("wr_cycle", cyc, ev.due);
          chk("wr_spi_data", spi_data, ev.data);
          chk("wr_grant", grant, ev.grant);
        end
      end else if (wr !== 1'b0) begin
        chk("wr_known", wr, 0);
      end else if (wrq.size() != 0 && wrq[0].due <= cyc) begin
        void'(wrq.pop_front());
        n_cmp++;
        n_bad++;
        $display("FAIL wr_missing at cycle %0d: got wr=0 required wr=1", cyc);
      end

      if (drop === 1'b1) begin
        if (dropq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL drop_unexpected at cycle %0d: got drop=1 required drop=0", cyc);
        end else begin
          drop_ev_t dv;
          dv = dropq.pop_front();
          chk("drop_cycle", cyc, dv.due);
          chk("drop_count", drop_count, dv.cnt);
          chk("drop_spi_data_held", spi_data, dv.data);
        end
      end else if (drop !== 1'b0) begin
        chk("drop_known", drop, 0);
      end else if (dropq.size() != 0 && dropq[0].due <= cyc) begin
        void'(dropq.pop_front());
        n_cmp++;
        n_bad++;
        $display("FAIL drop_missing at cycle %0d: got drop=0 required drop=1", cyc);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    step(1, 0, 0, '0, '0, 0, 1);

    // Single write of zero from requester 0, then idle with FIFO empty.
    step(0, 1, 0, 32'h0, 32'h0, 0, 0);
    repeat (6) step(0, 0, 0, '0, '0, 0, 1);

    // Continuous contention: grants alternate, wr every 2+GAP cycles.
    repeat (16) step(0, 1, 1, 32'h8000_0000, 32'h0000_0001, 0, 0);
    repeat (6) step(0, 0, 0, '0, '0, 0, 0);

    // Full stall shorter than the timeout, then release.
    repeat (10) step(0, 0, 1, 32'h0, 32'hA5A5_5A5A, 1, 0);
    repeat (4) step(0, 0, 1, 32'h0, 32'h1234_5678, 0, 0);
    repeat (6) step(0, 0, 0, '0, '0, 0, 0);

    // Held full: forced accept at stall cycle TO-1, drop one cycle later.
    repeat (TO + 6) step(0, 1, 0, 32'hDEAD_BEEF, 32'h0, 1, 0);
    repeat (4) step(0, 0, 0, '0, '0, 0, 1);

    // Reset in the WRITE cycle, then contention must restart at requester 0.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h0, 32'h0000_0BAD, 0, 0);
    for (int i = 0; i < 20 && !last_acc; i++) step(0, 1, 1, 32'h1111_1111, 32'h2222_2222, 0, 0);
    chk("reached_write_before_rst", last_acc, 1);
    step(1, 1, 1, 32'h1111_1111, 32'h2222_2222, 0, 0);
    repeat (8) step(0, 1, 1, 32'h3333_3333, 32'h4444_4444, 0, 0);

    // Randomized traffic with random full/empty and occasional reset.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(299) == 0), ($urandom_range(9) < 6), ($urandom_range(9) < 6),
           $urandom, $urandom, ($urandom_range(3) == 0), $urandom_range(1));
    end
    repeat (6) step(0, 0, 0, '0, '0, 0, 1);

    // Drop counter saturation: well over 255 forced drops.
    for (int i = 0; i < 300 * TO + 8; i++) begin
      step(0, $urandom_range(1), 1'b1, $urandom, $urandom, 1, 0);
    end
    step(0, 0, 0, '0, '0, 1, 0);
    chk("drop_count_saturated", drop_count, 8'd255);
    repeat (6) step(0, 0, 0, '0, '0, 0, 1);

    chk("wr_events_left", wrq.size(), 0);
    chk("drop_events_left", dropq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
